bias_weight_table_sat: RTL and testbench
========================================

// Module: bias_weight_table_sat
// PURPOSE
//  Parametrised bias-weight store for the bias-free neural branch predictor.
//  Holds DEPTH signed WIDTH-bit weights with a registered prediction read port.
//  Commits training as a 2-stage saturating read-modify-write, with forwarding.
//  Keeps a shift history of the last HIST read weights for the perceptron adder tree.
//  Clears itself after reset with a sweep FSM. Sits between fetch-PC hashing and the sum/threshold stage.
// PARAMETERS
//  DEPTH    1024            number of table entries (power of two)
//  WIDTH    6               weight width, signed two's complement
//  HIST     3               number of past read weights kept in hist_weights
//  INDEX_W  $clog2(DEPTH)   index width (derived, do not override)
// PORTS
//  clk           in   1             rising-edge clock, sole clock of the block
//  rst_n         in   1             synchronous, active-low reset
//  ready         out  1             1 = table initialised; pred/upd requests accepted
//  pred_valid    in   1             prediction lookup request
//  pred_index    in   INDEX_W       lookup index
//  pred_weight   out  WIDTH         weight read for the request of the previous cycle
//  pred_wvalid   out  1             pred_weight valid (1-cycle pulse per accepted lookup)
//  hist_weights  out  HIST*WIDTH    history; newest weight in the MS slice
//  upd_valid     in   1             training request
//  upd_index     in   INDEX_W       entry to train
//  upd_inc       in   1             1 = increment by 1, 0 = decrement by 1
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - FSM enters INIT; init_ptr=0.
//   - ready, pred_weight, pred_wvalid and hist_weights are all 0.
//   - Update pipeline valid bits are cleared; an in-flight update is discarded.
//  FSM INIT:
//   - Each cycle writes 0 to table[init_ptr], then init_ptr++.
//   - After writing entry DEPTH-1, goes to RUN; ready=1 from the next cycle.
//   - INIT lasts exactly DEPTH cycles. pred_valid and upd_valid are ignored during INIT.
//  FSM RUN:
//   - Stays in RUN until reset. Reset mid-operation re-enters INIT and re-clears the whole table.
//  Lookup (RUN):
//   - pred_valid at edge T gives pred_wvalid=1 and pred_weight=table[pred_index] after edge T.
//   - Latency is 1 cycle. With pred_valid=0, pred_wvalid=0 and pred_weight holds its value.
//  History:
//   - On each edge with pred_wvalid set, hist <= {pred_weight, hist[HIST*WIDTH-1:WIDTH]}.
//   - The oldest weight drops off the LS slice.
//  Update pipeline (RUN):
//   - Stage U1 (edge T): latch idx, inc and old=table[idx].
//   - Stage U2 (edge T+1): table[idx] <= sat(old ± 1).
//   - Accepts one update per cycle, fully pipelined; there is no backpressure.
//  Saturation:
//   - Range is -2^(WIDTH-1) .. 2^(WIDTH-1)-1. +1 at max and -1 at min leave the value unchanged.
//   - Compute in WIDTH+1 bits, then clamp.
//  Forwarding:
//   - An update in U1 whose idx matches the entry being committed in U2 uses the U2 result as old.
//   - Back-to-back updates to one index therefore accumulate with no lost increments.
//   - A lookup whose index matches the entry committed at the same edge returns the new value.
//   - A lookup matching an update still in U1 returns the pre-update value.
//  Simultaneous pred_valid and upd_valid to any indices are both serviced in the same cycle.
// TESTING
//  - Reset then DEPTH cycles idle -> ready rises after exactly DEPTH cycles. Lookup of idx 0, 5 and DEPTH-1 returns 0.
//  - Three back-to-back upd_inc=1 to idx 7, then lookup 7 -> pred_weight=3 one cycle after pred_valid.
//  - 40 increments to idx 9 (WIDTH=6) -> reads 31. Then 70 decrements -> reads -32 (6'b100000).
//  - Update idx 4 (+1) and lookup idx 4 at the commit edge -> pred_weight=1. Lookup one cycle earlier -> 0.
//  - Lookups returning 1, 2, 3, 4 -> hist_weights={4,3,2} (HIST=3).
//  - Assert rst_n=0 for one cycle while an update is in U1 -> ready=0 for DEPTH cycles. The entry reads 0 afterwards.

Source files
------------

// File: rtl/bias_weight_table_sat.sv
// Bias-weight table for the bias-free neural branch predictor: registered lookup port,
// saturating 2-stage training pipeline with forwarding, read history, post-reset clear sweep.
module bias_weight_table_sat #(
  parameter  int DEPTH   = 1024,
  parameter  int WIDTH   = 6,
  parameter  int HIST    = 3,
  localparam int INDEX_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    o_ready,
  input  logic                    i_pred_valid,
  input  logic [INDEX_W-1:0]      i_pred_index,
  output logic [WIDTH-1:0]        o_pred_weight,
  output logic                    o_pred_wvalid,
  output logic [HIST*WIDTH-1:0]   o_hist_weights,
  input  logic                    i_upd_valid,
  input  logic [INDEX_W-1:0]      i_upd_index,
  input  logic                    i_upd_inc
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  state_t               r_state;
  state_t               w_state_next;
  logic [INDEX_W-1:0]   r_init_ptr;
  logic [WIDTH-1:0]     r_table [DEPTH];

  logic                 r_u_valid;
  logic                 r_u_inc;
  logic [INDEX_W-1:0]   r_u_idx;
  logic [WIDTH-1:0]     r_u_old;

  logic                 w_run;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_new;
  logic                 w_u_fwd;
  logic                 w_p_fwd;
  logic                 w_we;
  logic [INDEX_W-1:0]   w_waddr;
  logic [WIDTH-1:0]     w_wdata;

  logic [HIST*WIDTH-1:0] r_hist;
  logic [HIST*WIDTH-1:0] w_hist_next;

  // State register and clear-sweep pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_INIT) begin
        r_init_ptr <= r_init_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_INIT && r_init_ptr == INDEX_W'(DEPTH - 1)) begin
      w_state_next = ST_RUN;
    end
  end

  assign w_run   = (r_state == ST_RUN);
  assign o_ready = w_run;

  // Increment/decrement in WIDTH+1 bits; a sign-bit disagreement means the step
  // left the representable range, so the weight stays at its rail.
  assign w_sum = {r_u_old[WIDTH-1], r_u_old} + (r_u_inc ? ONE_EXT : {(WIDTH+1){1'b1}});
  assign w_new = (w_sum[WIDTH] != w_sum[WIDTH-1]) ? r_u_old : w_sum[WIDTH-1:0];

  assign w_u_fwd = r_u_valid && (r_u_idx == i_upd_index);
  assign w_p_fwd = r_u_valid && (r_u_idx == i_pred_index);

  // Single write port shared by the clear sweep and the training commit
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_init_ptr;
    w_wdata = '0;
    if (!w_run) begin
      w_we = rst_n;
    end else if (r_u_valid) begin
      w_we    = rst_n;
      w_waddr = r_u_idx;
      w_wdata = w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_table[w_waddr] <= w_wdata;
    end
  end

  // Training stage U1: capture request and current weight (forwarded if committing now)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_u_valid <= 1'b0;
    end else begin
      r_u_valid <= w_run && i_upd_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_run && i_upd_valid) begin
      r_u_idx <= i_upd_index;
      r_u_inc <= i_upd_inc;
      r_u_old <= w_u_fwd ? w_new : r_table[i_upd_index];
    end
  end

  // Prediction read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_pred_weight <= '0;
      o_pred_wvalid <= 1'b0;
    end else begin
      o_pred_wvalid <= w_run && i_pred_valid;
      if (w_run && i_pred_valid) begin
        o_pred_weight <= w_p_fwd ? w_new : r_table[i_pred_index];
      end
    end
  end

  // History shift: each slice takes its upper neighbour, the top slice takes the new weight
  for (genvar gi = 0; gi < HIST; gi++) begin : g_hist
    if (gi == HIST - 1) begin : g_top
      assign w_hist_next[gi*WIDTH +: WIDTH] = o_pred_weight;
    end else begin : g_mid
      assign w_hist_next[gi*WIDTH +: WIDTH] = r_hist[(gi+1)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else if (o_pred_wvalid) begin
      r_hist <= w_hist_next;
    end
  end

  assign o_hist_weights = r_hist;

endmodule

// File: tb/tb_bias_weight_table_sat.sv
// Scoreboard bench for bias_weight_table_sat: lookups push expected weights, a negedge
// monitor pops them whenever the DUT pulses pred_wvalid.
module tb_bias_weight_table_sat;
  localparam int DEPTH = 64;
  localparam int WIDTH = 6;
  localparam int HIST  = 3;
  localparam int IW    = $clog2(DEPTH);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  o_ready;
  logic                  i_pred_valid;
  logic [IW-1:0]         i_pred_index;
  logic [WIDTH-1:0]      o_pred_weight;
  logic                  o_pred_wvalid;
  logic [HIST*WIDTH-1:0] o_hist_weights;
  logic                  i_upd_valid;
  logic [IW-1:0]         i_upd_index;
  logic                  i_upd_inc;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  bias_weight_table_sat #(.DEPTH(DEPTH), .WIDTH(WIDTH), .HIST(HIST)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .o_ready        (o_ready),
    .i_pred_valid   (i_pred_valid),
    .i_pred_index   (i_pred_index),
    .o_pred_weight  (o_pred_weight),
    .o_pred_wvalid  (o_pred_wvalid),
    .o_hist_weights (o_hist_weights),
    .i_upd_valid    (i_upd_valid),
    .i_upd_index    (i_upd_index),
    .i_upd_inc      (i_upd_inc)
  );

  // Monitor: one line per returned lookup
  always @(negedge clk) begin : monitor
    logic [WIDTH-1:0] e;
    if (mon_en && o_pred_wvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wvalid: got weight %0d, required no lookup response",
                 $signed(o_pred_weight));
      end else begin
        e = exp_q.pop_front();
        if (o_pred_weight !== e) begin
          errors++;
          $display("FAIL lookup: got weight %0d, required %0d", $signed(o_pred_weight), $signed(e));
        end else begin
          $display("lookup ok: weight %0d", $signed(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end else begin
      $display("check %s ok: 0x%0h", name, got);
    end
  endtask

  task automatic lookup(input int idx, input logic [WIDTH-1:0] req);
    i_pred_valid = 1'b1;
    i_pred_index = IW'(idx);
    exp_q.push_back(req);
    tick();
    i_pred_valid = 1'b0;
  endtask

  task automatic upd(input int idx, input logic inc);
    i_upd_valid = 1'b1;
    i_upd_index = IW'(idx);
    i_upd_inc   = inc;
    tick();
    i_upd_valid = 1'b0;
  endtask

  // Counts cycles from reset release until ready rises; bounded
  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < DEPTH + 20) begin
      tick();
      n++;
    end
    check("init_cycles", 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    i_pred_valid = 1'b0;
    i_pred_index = '0;
    i_upd_valid  = 1'b0;
    i_upd_index  = '0;
    i_upd_inc    = 1'b0;
    tick();
    tick();
    mon_en = 1'b1;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_wvalid", 32'(o_pred_wvalid), 32'd0);
    check("rst_weight", 32'(o_pred_weight), 32'd0);
    check("rst_hist", 32'(o_hist_weights), 32'd0);

    // Requests during the sweep must be ignored
    rst_n        = 1'b1;
    i_pred_valid = 1'b1;
    i_pred_index = IW'(5);
    i_upd_valid  = 1'b1;
    i_upd_index  = IW'(5);
    i_upd_inc    = 1'b1;
    wait_ready();
    i_pred_valid = 1'b0;
    i_upd_valid  = 1'b0;

    lookup(0, 6'd0);
    lookup(5, 6'd0);
    lookup(DEPTH - 1, 6'd0);

    // Back-to-back training accumulates through forwarding
    for (int k = 0; k < 3; k++) upd(7, 1'b1);
    lookup(7, 6'd3);

    // Saturation at both rails
    for (int k = 0; k < 40; k++) upd(9, 1'b1);
    lookup(9, 6'd31);
    for (int k = 0; k < 70; k++) upd(9, 1'b0);
    lookup(9, 6'b100000);

    // Lookup alongside the update sees the old value; at the commit edge it sees the new one
    i_upd_valid  = 1'b1;
    i_upd_index  = IW'(4);
    i_upd_inc    = 1'b1;
    i_pred_valid = 1'b1;
    i_pred_index = IW'(4);
    exp_q.push_back(6'd0);
    tick();
    i_upd_valid = 1'b0;
    lookup(4, 6'd1);

    // History: entries 10..13 hold 1..4
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j <= k; j++) upd(10 + k, 1'b1);
    end
    tick();
    for (int k = 0; k < 4; k++) lookup(10 + k, WIDTH'(k + 1));
    tick();
    check("hist_4_3_2", 32'(o_hist_weights), 32'({6'd4, 6'd3, 6'd2}));
    check("idle_wvalid", 32'(o_pred_wvalid), 32'd0);
    check("weight_hold", 32'(o_pred_weight), 32'd4);

    // Reset while an update sits in U1
    i_upd_valid = 1'b1;
    i_upd_index = IW'(20);
    i_upd_inc   = 1'b1;
    tick();
    i_upd_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mid_rst_ready", 32'(o_ready), 32'd0);
    check("mid_rst_weight", 32'(o_pred_weight), 32'd0);
    check("mid_rst_hist", 32'(o_hist_weights), 32'd0);
    rst_n = 1'b1;
    wait_ready();
    lookup(20, 6'd0);
    lookup(7, 6'd0);
    lookup(9, 6'd0);

    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
